// File: rtl/img_sram_sequencer.sv
// Sequences the image pipeline RX -> CONV -> TX, handing img_sram to one requester at a time
// with an idle gap between phases and a watchdog on each child's start acknowledge.
package img_sram_pkg;
  typedef struct packed {
    logic        cs;
    logic        we;
    logic [11:0] addr;
    logic [15:0] wdata;
  } img_sram_ctrl_t;
endpackage

module img_sram_sequencer
  import img_sram_pkg::*;
#(
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  input  logic           bypass,
  input  logic           abort,
  input  logic           rx_busy,
  input  logic           conv_busy,
  input  logic           tx_busy,
  output logic           rx_en,
  output logic           conv_en,
  output logic           tx_en,
  input  img_sram_ctrl_t rx_sram_ctrl,
  input  img_sram_ctrl_t conv_sram_ctrl,
  input  img_sram_ctrl_t tx_sram_ctrl,
  output img_sram_ctrl_t sram_ctrl,
  output logic [2:0]     phase,
  output logic           busy,
  output logic           done,
  output logic           err
);

  if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
    $error("GAP_CYCLES must be in 1..15");
  end
  if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 15) begin : g_bad_ack
    $error("ACK_TIMEOUT must be in 1..15");
  end

  localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES);
  localparam logic [3:0] WDOG_LOAD = 4'(ACK_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE, S_RX_GO, S_RX_RUN, S_GAP_A, S_CV_GO,
    S_CV_RUN, S_GAP_B, S_TX_GO, S_TX_RUN, S_DONE
  } state_t;

  state_t     r_state;
  logic [3:0] r_gap_cnt;
  logic [3:0] r_wdog_cnt;
  logic       r_bypass;
  logic       r_err;
  logic       r_rx_en;
  logic       r_conv_en;
  logic       r_tx_en;
  logic       r_done;

  logic       w_child_busy;
  state_t     w_run_state;

  always_comb begin
    w_child_busy = 1'b0;
    w_run_state  = S_IDLE;
    case (r_state)
      S_RX_GO, S_RX_RUN: begin
        w_child_busy = rx_busy;
        w_run_state  = S_RX_RUN;
      end
      S_CV_GO, S_CV_RUN: begin
        w_child_busy = conv_busy;
        w_run_state  = S_CV_RUN;
      end
      S_TX_GO, S_TX_RUN: begin
        w_child_busy = tx_busy;
        w_run_state  = S_TX_RUN;
      end
      default: ;
    endcase
  end

  // Enable pulses are registered on the transition into x_GO so they cover its first cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_gap_cnt  <= '0;
      r_wdog_cnt <= '0;
      r_bypass   <= 1'b0;
      r_err      <= 1'b0;
      r_rx_en    <= 1'b0;
      r_conv_en  <= 1'b0;
      r_tx_en    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rx_en   <= 1'b0;
      r_conv_en <= 1'b0;
      r_tx_en   <= 1'b0;
      r_done    <= 1'b0;
      if (abort) begin
        r_state    <= S_IDLE;
        r_gap_cnt  <= '0;
        r_wdog_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state    <= S_RX_GO;
              r_bypass   <= bypass;
              r_err      <= 1'b0;
              r_rx_en    <= 1'b1;
              r_wdog_cnt <= WDOG_LOAD;
            end
          end
          S_RX_GO, S_CV_GO, S_TX_GO: begin
            if (w_child_busy) begin
              r_state    <= w_run_state;
              r_wdog_cnt <= '0;
            end else if (r_wdog_cnt <= 4'd1) begin
              r_state    <= S_IDLE;
              r_err      <= 1'b1;
              r_wdog_cnt <= '0;
            end else begin
              r_wdog_cnt <= r_wdog_cnt - 4'd1;
            end
          end
          S_RX_RUN: begin
            if (!rx_busy) begin
              r_state   <= S_GAP_A;
              r_gap_cnt <= GAP_LOAD;
            end
          end
          S_CV_RUN: begin
            if (!conv_busy) begin
              r_state   <= S_GAP_B;
              r_gap_cnt <= GAP_LOAD;
            end
          end
          S_TX_RUN: begin
            if (!tx_busy) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
          S_GAP_A, S_GAP_B: begin
            if (r_gap_cnt <= 4'd1) begin
              r_gap_cnt  <= '0;
              r_wdog_cnt <= WDOG_LOAD;
              if (r_state == S_GAP_A && !r_bypass) begin
                r_state   <= S_CV_GO;
                r_conv_en <= 1'b1;
              end else begin
                r_state <= S_TX_GO;
                r_tx_en <= 1'b1;
              end
            end else begin
              r_gap_cnt <= r_gap_cnt - 4'd1;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    phase     = 3'd0;
    sram_ctrl = '0;
    case (r_state)
      S_RX_GO, S_RX_RUN: begin
        phase     = 3'd1;
        sram_ctrl = rx_sram_ctrl;
      end
      S_CV_GO, S_CV_RUN: begin
        phase     = 3'd2;
        sram_ctrl = conv_sram_ctrl;
      end
      S_TX_GO, S_TX_RUN: begin
        phase     = 3'd3;
        sram_ctrl = tx_sram_ctrl;
      end
      S_GAP_A, S_GAP_B: phase = 3'd4;
      S_DONE:           phase = 3'd5;
      default: ;
    endcase
  end

  assign busy    = (r_state != S_IDLE);
  assign rx_en   = r_rx_en;
  assign conv_en = r_conv_en;
  assign tx_en   = r_tx_en;
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_img_sram_sequencer.sv
// Randomized scoreboard bench for img_sram_sequencer: a timeline model predicts phase changes,
// enable pulses, done and err edges; a negedge monitor compares them as the DUT produces them.
module tb_img_sram_sequencer;
  import img_sram_pkg::*;

  localparam int G     = 2;
  localparam int AT    = 4;
  localparam int NCYC  = 8192;
  localparam int NEVER = 31;
  localparam int CW    = $bits(img_sram_ctrl_t);
  localparam int K_PH = 0, K_EN = 1, K_DONE = 2, K_ERR = 3;

  logic clk = 1'b0;
  logic rstn, start, bypass, abort, rx_busy, conv_busy, tx_busy;
  logic rx_en, conv_en, tx_en, busy, done, err;
  logic [2:0] phase;
  img_sram_ctrl_t rx_ctrl, cv_ctrl, tx_ctrl, sram_ctrl;

  img_sram_sequencer #(.GAP_CYCLES(G), .ACK_TIMEOUT(AT)) dut (
    .clk(clk), .rstn(rstn), .start(start), .bypass(bypass), .abort(abort),
    .rx_busy(rx_busy), .conv_busy(conv_busy), .tx_busy(tx_busy),
    .rx_en(rx_en), .conv_en(conv_en), .tx_en(tx_en),
    .rx_sram_ctrl(rx_ctrl), .conv_sram_ctrl(cv_ctrl), .tx_sram_ctrl(tx_ctrl),
    .sram_ctrl(sram_ctrl), .phase(phase), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int val; int cyc; } ev_t;
  ev_t sb_q[$];
  int  exp_ph[NCYC];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  m_err = 1'b0;
  int  ack_c[3];
  int  run_c[3];

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #(NCYC * 10);
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1, "bench time limit exceeded");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, expv);
    end
  endtask

  task automatic observe(input int k, input int v);
    ev_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL event at cycle %0d: got kind %0d val %0d, want nothing", cyc, k, v);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != k || e.val != v || e.cyc != cyc) begin
        n_bad++;
        $display("FAIL event: got kind %0d val %0d cycle %0d, want kind %0d val %0d cycle %0d",
                 k, v, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  // Child stubs: busy rises ack cycles after the en pulse and stays high run cycles.
  initial begin
    int  t0[3];
    int  lack[3];
    int  lrun[3];
    bit  act[3];
    bit  bsy[3];
    logic en_i;
    rx_busy = 1'b0; conv_busy = 1'b0; tx_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      t0[i] = 0; lack[i] = 0; lrun[i] = 0; act[i] = 1'b0; bsy[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        case (i)
          0:       en_i = rx_en;
          1:       en_i = conv_en;
          default: en_i = tx_en;
        endcase
        if (en_i === 1'b1) begin
          t0[i] = cyc; lack[i] = ack_c[i]; lrun[i] = run_c[i]; act[i] = 1'b1;
        end
        bsy[i] = act[i] && lack[i] != NEVER && cyc >= t0[i] + lack[i] &&
                 cyc < t0[i] + lack[i] + lrun[i];
      end
      rx_busy = bsy[0]; conv_busy = bsy[1]; tx_busy = bsy[2];
    end
  end

  initial begin
    rx_ctrl = '0; cv_ctrl = '0; tx_ctrl = '0;
    forever begin
      @(posedge clk);
      #1;
      rx_ctrl = img_sram_ctrl_t'(CW'($urandom));
      cv_ctrl = img_sram_ctrl_t'(CW'($urandom));
      tx_ctrl = img_sram_ctrl_t'(CW'($urandom));
    end
  end

  // Monitor: reset state, then events and per-cycle sram_ctrl/busy against the model's phase.
  initial begin
    int prev_ph;
    logic prev_err;
    int ep;
    img_sram_ctrl_t exp_ctrl;
    prev_ph = 0;
    prev_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_phase", 32'(phase), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_en", 32'({rx_en, conv_en, tx_en}), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_sram_ctrl", 32'(sram_ctrl), 0);
    forever begin
      @(negedge clk);
      if (32'(phase) != 32'(prev_ph)) begin
        observe(K_PH, int'(phase));
        prev_ph = int'(phase);
      end
      if (rx_en)   observe(K_EN, 1);
      if (conv_en) observe(K_EN, 2);
      if (tx_en)   observe(K_EN, 3);
      if (done)    observe(K_DONE, 1);
      if (err !== prev_err) begin
        observe(K_ERR, int'(err));
        prev_err = err;
      end
      ep = (cyc < NCYC) ? exp_ph[cyc] : 0;
      case (ep)
        1:       exp_ctrl = rx_ctrl;
        2:       exp_ctrl = cv_ctrl;
        3:       exp_ctrl = tx_ctrl;
        default: exp_ctrl = '0;
      endcase
      chk("busy", 32'(busy), 32'(ep != 0));
      chk("sram_ctrl", 32'(sram_ctrl), 32'(exp_ctrl));
    end
  end

  // Timeline of one accepted start at cycle T, cut short by abort or reset at cycle cut.
  task automatic model_txn(input bit byp, input int T, input int abort_c, input int rst_c,
                           output int last_c);
    ev_t l[$];
    ev_t kept[$];
    int t, e, cut, p, k;
    bit fin, ph_at, er_at;
    l.push_back(ev_t'{K_PH, 1, T});
    l.push_back(ev_t'{K_EN, 1, T});
    if (m_err) l.push_back(ev_t'{K_ERR, 0, T});
    t = T;
    fin = 1'b0;
    for (int ph = 1; ph <= 3; ph++) begin
      if (fin || (ph == 2 && byp)) continue;
      if (ph != 1) begin
        l.push_back(ev_t'{K_PH, ph, t});
        l.push_back(ev_t'{K_EN, ph, t});
      end
      if (ack_c[ph-1] >= AT) begin
        l.push_back(ev_t'{K_PH, 0, t + AT});
        l.push_back(ev_t'{K_ERR, 1, t + AT});
        fin = 1'b1;
      end else begin
        e = t + ack_c[ph-1] + run_c[ph-1] + 1;
        if (ph == 3) begin
          l.push_back(ev_t'{K_PH, 5, e});
          l.push_back(ev_t'{K_DONE, 1, e});
          l.push_back(ev_t'{K_PH, 0, e + 1});
          fin = 1'b1;
        end else begin
          l.push_back(ev_t'{K_PH, 4, e});
          t = e + G;
        end
      end
    end
    cut = -1;
    if (abort_c >= 0) cut = abort_c;
    if (rst_c >= 0 && (cut < 0 || rst_c < cut)) cut = rst_c;
    if (cut >= 0) begin
      ph_at = 1'b0;
      er_at = m_err;
      foreach (l[i]) begin
        if (l[i].cyc <= cut) begin
          kept.push_back(l[i]);
          if (l[i].kind == K_PH)  ph_at = (l[i].val != 0);
          if (l[i].kind == K_ERR) er_at = (l[i].val != 0);
        end
      end
      l = kept;
      if (ph_at) l.push_back(ev_t'{K_PH, 0, cut + 1});
      if (cut == rst_c && er_at) l.push_back(ev_t'{K_ERR, 0, cut + 1});
    end
    last_c = T;
    foreach (l[i]) begin
      if (l[i].cyc > last_c) last_c = l[i].cyc;
      if (l[i].kind == K_ERR) m_err = (l[i].val != 0);
      sb_q.push_back(l[i]);
    end
    p = 0;
    k = 0;
    for (int c = T; c <= last_c + 1 && c < NCYC; c++) begin
      while (k < l.size() && l[k].cyc == c) begin
        if (l[k].kind == K_PH) p = l[k].val;
        k++;
      end
      exp_ph[c] = p;
    end
  endtask

  task automatic set_children(input int a0, input int a1, input int a2,
                              input int r0, input int r1, input int r2);
    ack_c[0] = a0; ack_c[1] = a1; ack_c[2] = a2;
    run_c[0] = r0; run_c[1] = r1; run_c[2] = r2;
  endtask

  task automatic run_txn(input bit byp, input int hold, input int abort_off, input int rst_off,
                         input bit pre_rst, input bit abort_start);
    int C, S, T, ac, rc, last_c, end_c;
    @(negedge clk);
    C = cyc;
    S = pre_rst ? C + 1 : C;
    T = S + 1;
    if (pre_rst && m_err) begin
      sb_q.push_back(ev_t'{K_ERR, 0, C + 1});
      m_err = 1'b0;
    end
    ac = (abort_off >= 0) ? T + abort_off : -1;
    rc = (rst_off >= 0) ? T + rst_off : -1;
    if (abort_start) last_c = S;
    else model_txn(byp, T, ac, rc, last_c);
    end_c = last_c;
    if (ac > end_c) end_c = ac;
    if (rc > end_c) end_c = rc;
    end_c = end_c + 14;
    for (int c = C; c <= end_c; c++) begin
      rstn   = !((pre_rst && c == C) || c == rc);
      start  = (c >= S && c < S + hold);
      abort  = (abort_start && c == S) || (c == ac);
      bypass = (c == S) ? byp : 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    rstn  = 1'b1;
  endtask

  initial begin
    int r;
    rstn = 1'b0; start = 1'b0; bypass = 1'b0; abort = 1'b0;
    set_children(1, 1, 1, 1, 1, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    set_children(1, 1, 1, 10, 10, 10);      run_txn(1'b0, 1, -1, -1, 1'b0, 1'b0);
    set_children(1, 1, 1, 3, 3, 3);         run_txn(1'b1, 1, -1, -1, 1'b0, 1'b0);
    set_children(1, NEVER, 1, 2, 2, 2);     run_txn(1'b0, 1, -1, -1, 1'b0, 1'b0);
    set_children(2, 2, 2, 2, 2, 2);         run_txn(1'b0, 1, -1, -1, 1'b0, 1'b0);
    set_children(1, 1, NEVER, 2, 2, 2);     run_txn(1'b1, 1, -1, -1, 1'b0, 1'b0);
    set_children(1, 1, 1, 2, 2, 2);         run_txn(1'b0, 1, -1, -1, 1'b1, 1'b0);
    set_children(NEVER, 1, 1, 2, 2, 2);     run_txn(1'b0, 1, -1, -1, 1'b0, 1'b0);
    set_children(1, 1, 1, 4, 4, 4);         run_txn(1'b0, 1, 19, -1, 1'b0, 1'b0);
    set_children(1, 1, 1, 4, 4, 4);         run_txn(1'b0, 5, -1, 11, 1'b0, 1'b0);
    set_children(0, 0, 0, 1, 1, 1);         run_txn(1'b0, 1, -1, -1, 1'b0, 1'b0);
    set_children(AT - 1, AT - 1, AT - 1, 2, 1, 3); run_txn(1'b0, 1, -1, -1, 1'b0, 1'b0);
    set_children(1, AT, 1, 2, 2, 2);        run_txn(1'b0, 1, -1, -1, 1'b0, 1'b0);
    set_children(1, 1, 1, 2, 2, 2);         run_txn(1'b0, 1, -1, -1, 1'b0, 1'b1);

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 3; i++) begin
        ack_c[i] = ($urandom_range(0, 7) == 0) ? AT + int'($urandom_range(0, 1))
                                               : int'($urandom_range(0, AT - 1));
        run_c[i] = int'($urandom_range(1, 6));
      end
      r = int'($urandom_range(0, 9));
      case (r)
        0: run_txn(1'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(3, 30)), -1,
                   1'b0, 1'b0);
        1: run_txn(1'($urandom), int'($urandom_range(1, 3)), -1, int'($urandom_range(3, 30)),
                   1'b0, 1'b0);
        2: run_txn(1'($urandom), 1, -1, -1, 1'b0, 1'b1);
        3: run_txn(1'($urandom), 1, -1, -1, 1'b1, 1'b0);
        default: run_txn(1'($urandom), int'($urandom_range(1, 3)), -1, -1, 1'b0, 1'b0);
      endcase
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/img_sram_sequencer.md
IMG_SRAM_SEQUENCER -- requirements
Module: img_sram_sequencer

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2: idle cycles between phases, during which sram_ctrl is all-zero (range 1..15).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 4: max cycles after an en pulse for the phase's busy to assert (range 1..15).
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rstn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  in  1  one-cycle request to run RX -> CONV -> TX.
REQ-006 SHALL have port bypass  in  1  skip CONV phase; sampled only on an accepted start.
REQ-007 SHALL have port abort  in  1  return to IDLE immediately.
REQ-008 SHALL have ports rx_busy, conv_busy, tx_busy  in  1 each  child controller busy flags.
REQ-009 SHALL have ports rx_en, conv_en, tx_en  out  1 each  one-cycle child start pulses.
REQ-010 SHALL have ports rx_sram_ctrl, conv_sram_ctrl, tx_sram_ctrl  in  img_sram_ctrl_t  requester SRAM controls.
REQ-011 SHALL have port sram_ctrl  out  img_sram_ctrl_t  control to img_sram.
REQ-012 SHALL have port phase  out  3  0=IDLE,1=RX,2=CONV,3=TX,4=GAP,5=DONE.
REQ-013 SHALL have ports busy  out  1 (state != IDLE); done  out  1 (one-cycle pulse); err  out  1 (sticky ack-timeout flag).

Function
REQ-014 SHALL implement states IDLE, RX_GO, RX_RUN, GAP_A, CV_GO, CV_RUN, GAP_B, TX_GO, TX_RUN, DONE.
REQ-015 IDLE: start=1 and abort=0 SHALL go to RX_GO, latch bypass, clear err; start in any other state SHALL be ignored.
REQ-016 x_GO states SHALL assert matching x_en for exactly one cycle (the first cycle of x_GO), then hold in x_GO until x_busy=1, then go to x_RUN.
REQ-017 In x_GO, a watchdog SHALL count cycles after the en pulse; if x_busy not seen within ACK_TIMEOUT cycles: set err, go IDLE, no done pulse.
REQ-018 x_RUN SHALL go to the next state the cycle after x_busy is sampled 0.
REQ-019 Successors: RX_RUN->GAP_A; GAP_A->CV_GO, or TX_GO when bypass latched; CV_RUN->GAP_B; GAP_B->TX_GO; TX_RUN->DONE; DONE->IDLE after one cycle.
REQ-020 GAP_A/GAP_B SHALL last exactly GAP_CYCLES cycles (4-bit down-counter reloaded on entry).
REQ-021 sram_ctrl SHALL be combinational: rx_sram_ctrl in RX_GO/RX_RUN, conv_sram_ctrl in CV_GO/CV_RUN, tx_sram_ctrl in TX_GO/TX_RUN, all-zero otherwise.
REQ-022 done SHALL pulse one cycle while in DONE; busy SHALL be 0 only in IDLE.
REQ-023 abort=1 SHALL force IDLE next edge from any state, takes priority over start and all transitions; err unchanged; no done.
REQ-024 If x_busy already 1 on x_GO entry, SHALL still pulse x_en once and advance to x_RUN next cycle.
REQ-025 phase SHALL be 1/2/3 for RX_*/CV_*/TX_*, 4 for GAP_*, 5 for DONE, 0 for IDLE.

Reset
REQ-026 rstn=0 at a rising edge SHALL set state IDLE, counters 0, bypass latch 0, err 0; all en, done, busy 0; sram_ctrl all-zero.
REQ-027 Reset mid-operation SHALL abandon the sequence with no done pulse; start on the first cycle after rstn=1 SHALL be accepted.

Verification
REQ-028 start, bypass=0; stub children busy 1 cycle after en, 10 cycles -> en pulses rx, conv, tx in order; sram_ctrl all-zero exactly 2 cycles per gap; done once; err=0.
REQ-029 start, bypass=1 -> conv_en never asserts; sequence RX, GAP, TX, DONE; phase never 2.
REQ-030 conv_busy never asserts -> err=1 exactly 4 cycles after conv_en; back to IDLE; tx_en never pulses; next start clears err.
REQ-031 abort during TX_RUN -> IDLE next cycle; sram_ctrl all-zero; no done; err unchanged.
REQ-032 rstn=0 during CV_RUN, start held high in RX_RUN -> reset clears all outputs; held start not re-triggering; rx_en pulses once per accepted start.
